// File: rtl/rv_mem_pkg.sv
// ----------------------------------------------------------------------------
// rv_mem_pkg
//
// Shared definitions for the data memory responder:
//   - RV32 load/store width codes (funct3) as seen on req_memop
//   - responder FSM state encoding
//   - latched request record
//   - helper to test whether a width code is usable for a given direction
// ----------------------------------------------------------------------------
package rv_mem_pkg;

    // RV32 funct3 width codes. Codes 011, 110 and 111 are never legal;
    // the unsigned codes only make sense for loads.
    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    // Responder sequencing: accept, touch storage, present response.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Request fields captured on acceptance; only these are used afterwards.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  memop;
    } mem_req_t;

    // True when the width code is meaningful for the requested direction.
    function automatic logic memop_legal(input logic we, input logic [2:0] memop);
        logic legal;
        case (memop)
            MEMOP_B, MEMOP_H, MEMOP_W: legal = 1'b1;
            MEMOP_BU, MEMOP_HU:        legal = ~we;
            default:                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// ----------------------------------------------------------------------------
// load_store_align
//
// Purely combinational lane steering between a 32-bit storage word and the
// right-aligned data seen by the initiator.
//
// Ports
//   memop_i       in   3  RV32 width code of the access
//   addr_lo_i     in   2  byte offset within the word
//   we_i          in   1  1 = store, 0 = load
//   wdata_i       in  32  right-aligned store data
//   rword_i       in  32  current contents of the addressed storage word
//   byte_en_o     out  4  bytes of the word a store should update
//   wdata_rep_o   out 32  store data replicated onto every lane
//   rdata_o       out 32  extracted and extended load value
//   misaligned_o  out  1  access not naturally aligned for its width
//   illegal_o     out  1  width code not usable for this direction
// ----------------------------------------------------------------------------
module load_store_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  memop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_rep_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Byte and halfword lanes of the stored word picked by the low address.
    always_comb begin
        lane_byte = rword_i[7:0];
        case (addr_lo_i)
            2'd0:    lane_byte = rword_i[7:0];
            2'd1:    lane_byte = rword_i[15:8];
            2'd2:    lane_byte = rword_i[23:16];
            default: lane_byte = rword_i[31:24];
        endcase
        lane_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        byte_en_o    = 4'b0000;
        wdata_rep_o  = wdata_i;
        rdata_o      = 32'd0;
        misaligned_o = 1'b0;
        illegal_o    = ~memop_legal(we_i, memop_i);

        case (memop_i)
            MEMOP_B, MEMOP_BU: begin
                byte_en_o   = 4'b0001 << addr_lo_i;
                wdata_rep_o = {4{wdata_i[7:0]}};
                // memop bit 2 marks the unsigned (zero-extending) variants.
                rdata_o     = memop_i[2] ? {24'd0, lane_byte}
                                         : {{24{lane_byte[7]}}, lane_byte};
            end
            MEMOP_H, MEMOP_HU: begin
                misaligned_o = addr_lo_i[0];
                byte_en_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o  = {2{wdata_i[15:0]}};
                rdata_o      = memop_i[2] ? {16'd0, lane_half}
                                          : {{16{lane_half[15]}}, lane_half};
            end
            MEMOP_W: begin
                misaligned_o = (addr_lo_i != 2'b00);
                byte_en_o    = 4'b1111;
                wdata_rep_o  = wdata_i;
                rdata_o      = rword_i;
            end
            default: begin
                byte_en_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//
// Single-ported word-organised data memory behind a valid/ready request and
// valid/ready response channel. Each access takes three cycles:
// IDLE (accept) -> ACCESS (storage read/write) -> RESP (hold until consumed).
//
// Parameters
//   DEPTH_WORDS   number of 32-bit words of storage (power of two, >= 4)
//
// Ports
//   clk           in   1  clock, rising edge
//   reset         in   1  asynchronous active-high reset
//   req_valid     in   1  initiator presents an access
//   req_ready     out  1  responder is idle and will accept this cycle
//   req_we        in   1  1 = store, 0 = load
//   req_addr      in  32  byte address
//   req_wdata     in  32  right-aligned store data
//   req_memop     in   3  RV32 funct3 width code
//   resp_valid    out  1  response is available
//   resp_ready    in   1  initiator consumes the response
//   resp_rdata    out 32  extended load data; 0 for stores and errors
//   resp_err      out  1  access rejected (misaligned, illegal, out of range)
// ----------------------------------------------------------------------------
module data_mem_responder
    import rv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_memop,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_e      state_q, state_d;
    mem_req_t    req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic             out_of_range;
    logic [31:0]      rword;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_rep;
    logic [31:0]      load_data;
    logic             misaligned;
    logic             illegal;
    logic             access_err;
    logic             do_write;

    // ------------------------------------------------------------------
    // Address decode and lane steering, all from the latched request.
    // ------------------------------------------------------------------
    assign word_idx     = req_q.addr[IDX_W+1:2];
    // Any address bit above the storage window makes the access invalid.
    assign out_of_range = (req_q.addr >> (IDX_W + 2)) != 32'd0;
    assign rword        = mem_q[word_idx];

    load_store_align u_align (
        .memop_i      (req_q.memop),
        .addr_lo_i    (req_q.addr[1:0]),
        .we_i         (req_q.we),
        .wdata_i      (req_q.wdata),
        .rword_i      (rword),
        .byte_en_o    (byte_en),
        .wdata_rep_o  (wdata_rep),
        .rdata_o      (load_data),
        .misaligned_o (misaligned),
        .illegal_o    (illegal)
    );

    assign access_err = out_of_range | misaligned | illegal;
    assign do_write   = (state_q == ST_ACCESS) && req_q.we && !access_err;

    // ------------------------------------------------------------------
    // Next-state and response capture.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    req_d.memop = req_memop;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Stores and rejected accesses report zero data.
                err_d   = access_err;
                rdata_d = (access_err || req_q.we) ? 32'd0 : load_data;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: storage has no reset branch; clearing a RAM on reset is not
    // possible for a real array and its contents must survive a reset.
    // A reset during ACCESS forces state_q back to IDLE asynchronously,
    // so do_write drops before the edge and the store is abandoned.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Self-checking bench for data_mem_responder. A byte-array model of the low
// 64 bytes of storage predicts every response from the access rules
// (width, alignment, legality, range, extension).
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_memop;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks;
    int failures;

    // Model of bytes 0x00..0x3F of storage.
    logic [7:0] mdl [0:63];

    data_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_memop  (req_memop),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: predicts err/rdata and applies stores to the byte model.
    function automatic void ref_access(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [2:0] memop,
                                       output logic err, output logic [31:0] rdata);
        int size;
        logic [31:0] val;
        size  = (memop[1:0] == 2'd0) ? 1 : (memop[1:0] == 2'd1) ? 2 : 4;
        err   = 1'b0;
        rdata = 32'd0;
        if (memop == 3'b011 || memop == 3'b110 || memop == 3'b111) err = 1'b1;
        if (we && memop > 3'b010) err = 1'b1;
        if ((addr % size) != 0) err = 1'b1;
        if (addr >= 32'(4 * DEPTH)) err = 1'b1;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) mdl[int'(addr) + i] = wdata[8*i +: 8];
        end else begin
            val = 32'd0;
            for (int i = 0; i < size; i++) val[8*i +: 8] = mdl[int'(addr) + i];
            if (!memop[2] && size < 4 && val[8*size-1]) begin
                for (int j = 8 * size; j < 32; j++) val[j] = 1'b1;
            end
            rdata = val;
        end
    endfunction

    // Drives one request from IDLE with resp_ready high. lat counts edges
    // from the accept edge (edge 1) up to the one after which resp_valid
    // is seen; returns once the responder is back in IDLE.
    task automatic do_txn(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] memop,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output bit timeout);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_memop = memop;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_memop = 3'($urandom);
        lat       = 1;
        timeout   = 1'b0;
        while (!resp_valid) begin
            if (lat > 8) begin
                timeout = 1'b1;
                break;
            end
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        if (!timeout) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_memop  = 3'd0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: ready=%b valid=%b required 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_word();
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        bit to;
        ref_access(1'b1, 32'h10, 32'hDEADBEEF, OP_W, ee, er);
        do_txn(1'b1, 32'h10, 32'hDEADBEEF, OP_W, r, e, lat, to);
        checks++;
        if (to || lat !== 2 || r !== 32'd0 || e !== 1'b0) begin
            failures++;
            $display("FAIL store_word: timeout=%0d lat=%0d rdata=%h err=%b required 0 2 00000000 0", to, lat, r, e);
        end
        ref_access(1'b0, 32'h10, 32'd0, OP_W, ee, er);
        do_txn(1'b0, 32'h10, 32'd0, OP_W, r, e, lat, to);
        checks++;
        if (to || lat !== 2 || r !== 32'hDEADBEEF || e !== 1'b0) begin
            failures++;
            $display("FAIL load_word: timeout=%0d lat=%0d rdata=%h err=%b required 0 2 deadbeef 0", to, lat, r, e);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL resp_clear: valid=%b rdata=%h err=%b ready=%b required 0 00000000 0 1",
                     resp_valid, resp_rdata, resp_err, req_ready);
        end
    endtask

    task automatic test_extend();
        logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h10, 32'h10};
        logic [2:0]  ops   [4] = '{OP_B, OP_BU, OP_HU, OP_H};
        logic [31:0] exps  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'h0000BEEF, 32'hFFFFBEEF};
        logic [31:0] r;
        logic e;
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b0, addrs[i], 32'd0, ops[i], r, e, lat, to);
            checks++;
            if (to || r !== exps[i] || e !== 1'b0) begin
                failures++;
                $display("FAIL extend_%0d: timeout=%0d rdata=%h err=%b required %h 0", i, to, r, e, exps[i]);
            end
        end
    endtask

    task automatic test_byte_store();
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        bit to;
        ref_access(1'b1, 32'h11, 32'h00000055, OP_B, ee, er);
        do_txn(1'b1, 32'h11, 32'h00000055, OP_B, r, e, lat, to);
        do_txn(1'b0, 32'h10, 32'd0, OP_W, r, e, lat, to);
        checks++;
        if (to || r !== 32'hDEAD55EF || e !== 1'b0) begin
            failures++;
            $display("FAIL byte_merge: timeout=%0d rdata=%h err=%b required dead55ef 0", to, r, e);
        end
    endtask

    task automatic test_errors();
        logic        wes   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] addrs [4] = '{32'h11, 32'h12, 32'h10, 32'h00001000};
        logic [2:0]  ops   [4] = '{OP_H, OP_W, 3'b011, OP_W};
        logic [31:0] r;
        logic e;
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            do_txn(wes[i], addrs[i], 32'hAAAA5A5A, ops[i], r, e, lat, to);
            checks++;
            if (to || e !== 1'b1 || r !== 32'd0) begin
                failures++;
                $display("FAIL error_%0d: timeout=%0d err=%b rdata=%h required 1 00000000", i, to, e, r);
            end
        end
        do_txn(1'b0, 32'h10, 32'd0, OP_W, r, e, lat, to);
        checks++;
        if (to || r !== 32'hDEAD55EF || e !== 1'b0) begin
            failures++;
            $display("FAIL error_no_write: rdata=%h err=%b required dead55ef 0", r, e);
        end
    endtask

    task automatic test_stall();
        logic [31:0] r;
        logic e;
        int lat;
        bit to;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h10;
        req_memop  = OP_W;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_enter: valid=%b required 1", resp_valid);
        end
        for (int c = 0; c < 5; c++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h10;
            req_wdata = 32'h0;
            req_memop = OP_W;
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD55EF || resp_err !== 1'b0 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold_%0d: valid=%b rdata=%h err=%b ready=%b required 1 dead55ef 0 0",
                         c, resp_valid, resp_rdata, resp_err, req_ready);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: valid=%b rdata=%h ready=%b required 0 00000000 1",
                     resp_valid, resp_rdata, req_ready);
        end
        do_txn(1'b0, 32'h10, 32'd0, OP_W, r, e, lat, to);
        checks++;
        if (to || r !== 32'hDEAD55EF) begin
            failures++;
            $display("FAIL stall_ignored_req: rdata=%h required dead55ef", r);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r, er;
        logic e, ee;
        int lat;
        bit to;
        ref_access(1'b1, 32'h20, 32'hCAFEF00D, OP_W, ee, er);
        do_txn(1'b1, 32'h20, 32'hCAFEF00D, OP_W, r, e, lat, to);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_memop = OP_W;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_access: ready=%b valid=%b rdata=%h err=%b required 1 0 00000000 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_txn(1'b0, 32'h20, 32'd0, OP_W, r, e, lat, to);
        checks++;
        if (to || r !== 32'hCAFEF00D || e !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_store: rdata=%h err=%b required cafef00d 0", r, e);
        end
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h20;
        req_memop  = OP_W;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL resp_before_reset: valid=%b rdata=%h required 1 cafef00d", resp_valid, resp_rdata);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_resp: valid=%b rdata=%h ready=%b required 0 00000000 1",
                     resp_valid, resp_rdata, req_ready);
        end
        @(posedge clk); #1;
        reset      = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int ready_seen;
        int valid_seen;
        int last_ready;
        int gap_bad;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h10;
        req_memop  = OP_W;
        ready_seen = 0;
        valid_seen = 0;
        last_ready = -1;
        gap_bad    = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (req_ready) begin
                if (last_ready >= 0 && c - last_ready != 3) gap_bad++;
                last_ready = c;
                ready_seen++;
            end
            if (resp_valid) begin
                valid_seen++;
                checks++;
                if (resp_rdata !== 32'hDEAD55EF || resp_err !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_data_c%0d: rdata=%h err=%b required dead55ef 0", c, resp_rdata, resp_err);
                end
            end
        end
        req_valid = 1'b0;
        checks++;
        if (ready_seen !== 4 || valid_seen !== 4 || gap_bad !== 0) begin
            failures++;
            $display("FAIL b2b_throughput: ready_cycles=%0d resp_cycles=%0d bad_gaps=%0d required 4 4 0",
                     ready_seen, valid_seen, gap_bad);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] r, er, addr, wdata;
        logic e, ee, we;
        logic [2:0] op;
        int lat;
        bit to;
        for (int w = 0; w < 16; w++) begin
            wdata = $urandom;
            ref_access(1'b1, 32'(4 * w), wdata, OP_W, ee, er);
            do_txn(1'b1, 32'(4 * w), wdata, OP_W, r, e, lat, to);
        end
        for (int n = 0; n < 300; n++) begin
            we    = 1'($urandom);
            op    = 3'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h00001000;
            else                           addr = $urandom_range(0, 63);
            ref_access(we, addr, wdata, op, ee, er);
            do_txn(we, addr, wdata, op, r, e, lat, to);
            checks++;
            if (to || lat !== 2 || r !== er || e !== ee) begin
                failures++;
                $display("FAIL rand_%0d we=%b addr=%h op=%b: timeout=%0d lat=%0d rdata=%h err=%b required lat 2 rdata %h err %b",
                         n, we, addr, op, to, lat, r, e, er, ee);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_word();
        test_extend();
        test_byte_store();
        test_errors();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: word count of internal storage (power of two, ≥4).
REQ-002 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1: reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  in  1: initiator presents an access.
REQ-005 SHALL have port req_ready  out  1: responder accepts an access this cycle.
REQ-006 SHALL have port req_we  in  1: 1 = store, 0 = load.
REQ-007 SHALL have port req_addr  in  32: byte address.
REQ-008 SHALL have port req_wdata  in  32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port req_memop  in  3: RV32 funct3 width code; 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port resp_valid  out  1: response available.
REQ-011 SHALL have port resp_ready  in  1: initiator consumes response.
REQ-012 SHALL have port resp_rdata  out  32: load result, extended to 32 bits; 0 for stores and errors.
REQ-013 SHALL have port resp_err  out  1: access rejected (misaligned, illegal memop, out of range).

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-015 IDLE: req_ready=1; req_valid=1 latches addr/wdata/memop/we and moves to ACCESS; otherwise stays.
REQ-016 ACCESS: req_ready=0; one cycle; storage accessed; unconditional move to RESP.
REQ-017 RESP: resp_valid=1 with stable rdata/err; stays until resp_ready=1, then IDLE.
REQ-018 Handshake latency: request accepted at edge N -> resp_valid high after edge N+2; back-to-back throughput one access per 3 cycles with resp_ready tied 1.
REQ-019 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; any set address bit above that range = out-of-range error.
REQ-020 Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00 -> error.
REQ-021 Illegal memop: 011, 110, 111 for loads; anything except 000/001/010 for stores -> error.
REQ-022 Erroring access: no storage write; resp_err=1; resp_rdata=0.
REQ-023 Store: byte enables from memop and addr[1:0]; wdata lane-replicated; only enabled bytes written at the ACCESS edge.
REQ-024 Load: lane selected by addr[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged; captured into resp_rdata at the ACCESS edge.
REQ-025 Load immediately following a store to the same word SHALL return the updated data.
REQ-026 req_valid ignored outside IDLE; fields latched in IDLE are the only ones used.
REQ-027 resp_rdata/resp_err SHALL hold until the RESP->IDLE transition, then clear to 0.

Reset
REQ-028 Reset asserted: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latched request fields cleared.
REQ-029 Reset in ACCESS SHALL abort the store (no byte written); reset in RESP drops the response.
REQ-030 Storage contents SHALL NOT be reset.

Structure
REQ-031 Package rv_mem_pkg SHALL hold memop encodings (MEMOP_B/H/W/BU/HU) and the FSM state enum.
REQ-032 Lane steering (byte enables, write replication, load extract/extend, misalignment check) SHALL live in one combinational sub-module, load_store_align.

Verification
REQ-033 Store W 0xDEADBEEF @0x10, then load W @0x10 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid at 2nd edge after accept.
REQ-034 After REQ-033, load B @0x13 -> 0xFFFFFFDE; load BU @0x13 -> 0x000000DE; load HU @0x10 -> 0x0000BEEF; load H @0x10 -> 0xFFFFBEEF.
REQ-035 Store B 0x55 @0x11 over 0xDEADBEEF, then load W @0x10 -> 0xDEAD55EF.
REQ-036 Store H @0x11, load W @0x12, memop 011, addr 0x00001000 (DEPTH 1024) -> each resp_err=1, resp_rdata=0, memory unchanged.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid/rdata stable, req_ready=0, new req_valid ignored.
REQ-038 Assert reset during ACCESS of store W 0x12345678 @0x20 -> outputs at reset values; subsequent load @0x20 returns prior contents.
